// File: rtl/frame_streamer.sv
// Streams one RGB565 frame from a sprite memory to an SPI LCD: RAMWR (0x2C) command byte, then NUM_PIXELS words.
// Optional macro AUTO_REFRESH_EN: frames repeat back to back after a single start, chip select held low.
module frame_streamer #(
    parameter int NUM_PIXELS = 38720,
    parameter int CLK_DIV    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  estado,
    output logic [2:0]  adress,
    output logic [15:0] contador_pixel,
    input  logic [15:0] pixel,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_dc,
    output logic        busy,
    output logic        frame_done
);

`ifdef AUTO_REFRESH_EN
    localparam bit AUTO_REFRESH = 1'b1;
`else
    localparam bit AUTO_REFRESH = 1'b0;
`endif

    localparam int                DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0]       LAST_PIXEL = 16'(NUM_PIXELS - 1);
    localparam logic [7:0]        CMD_RAMWR  = 8'h2C;

    typedef enum logic [2:0] {IDLE, CMD, LOAD, SHIFT, NEXT, DONE} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [15:0]      shreg;

    logic half_end;
    logic last_bit;
    logic launch;

    assign half_end = (div_cnt == DIV_LAST);
    assign last_bit = (state == CMD) ? (bit_cnt == 4'd7) : (bit_cnt == 4'd15);
    assign launch   = ((state == IDLE) && start) || ((state == DONE) && AUTO_REFRESH);

    // Sprite index 7 has no image behind it and falls back to sprite 0.
    function automatic logic [2:0] map_sprite(input logic [2:0] idx);
        return (idx == 3'd7) ? 3'd0 : idx;
    endfunction

    // NOTE: every register here, including the shift register, is reset so an abort leaves no stale bus state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            adress         <= '0;
            contador_pixel <= '0;
            spi_sclk       <= 1'b0;
            spi_mosi       <= 1'b0;
            spi_cs_n       <= 1'b1;
            spi_dc         <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
        end else begin
            frame_done <= 1'b0;
            if (launch) begin
                adress         <= map_sprite(estado);
                contador_pixel <= '0;
                spi_cs_n       <= 1'b0;
                busy           <= 1'b1;
                spi_dc         <= 1'b0;
                spi_mosi       <= CMD_RAMWR[7];
                shreg          <= {CMD_RAMWR[6:0], 9'd0};
                div_cnt        <= '0;
                bit_cnt        <= '0;
                state          <= CMD;
            end else begin
                case (state)
                    CMD, SHIFT: begin
                        // mosi only moves on the falling sclk edge, keeping it stable around the rise.
                        if (half_end) begin
                            div_cnt  <= '0;
                            spi_sclk <= ~spi_sclk;
                            if (spi_sclk) begin
                                if (last_bit) begin
                                    state <= (state == CMD) ? LOAD : NEXT;
                                end else begin
                                    spi_mosi <= shreg[15];
                                    shreg    <= {shreg[14:0], 1'b0};
                                    bit_cnt  <= bit_cnt + 4'd1;
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    LOAD: begin
                        spi_dc   <= 1'b1;
                        spi_mosi <= pixel[15];
                        shreg    <= {pixel[14:0], 1'b0};
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        state    <= SHIFT;
                    end
                    NEXT: begin
                        if (contador_pixel == LAST_PIXEL) begin
                            frame_done <= 1'b1;
                            if (!AUTO_REFRESH) begin
                                spi_cs_n <= 1'b1;
                                busy     <= 1'b0;
                            end
                            state <= DONE;
                        end else begin
                            contador_pixel <= contador_pixel + 16'd1;
                            state          <= LOAD;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/frame_streamer.md
FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 38720, pixels per frame (176x220).
REQ-002 SHALL have parameter CLK_DIV, default 2, clk cycles per SCLK half-period (>=1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle frame request.
REQ-006 SHALL have port estado  input  3  sprite/state index to display.
REQ-007 SHALL have port adress  output  3  sprite select to pixel memory.
REQ-008 SHALL have port contador_pixel  output  16  pixel index to pixel memory.
REQ-009 SHALL have port pixel  input  16  RGB565 word from memory, combinational on adress/contador_pixel.
REQ-010 SHALL have ports spi_sclk, spi_mosi, spi_cs_n, spi_dc  output  1 each  LCD serial bus (mode 0).
REQ-011 SHALL have ports busy, frame_done  output  1 each  frame in progress; one-cycle end-of-frame pulse.

Function
REQ-012 SHALL implement states IDLE, CMD, LOAD, SHIFT, NEXT, DONE.
REQ-013 IDLE: start=1 -> latch estado into adress (values 7 map to 0), contador_pixel=0, cs_n=0, busy=1, go CMD.
REQ-014 start while busy=1 SHALL be ignored; adress SHALL stay constant for the whole frame regardless of estado changes.
REQ-015 CMD: shift byte 0x2C MSB first with spi_dc=0, then go LOAD.
REQ-016 LOAD: capture pixel into a 16-bit shift register exactly one cycle after contador_pixel settles; spi_dc=1; go SHIFT.
REQ-017 SHIFT: 16 bits MSB first; each bit = 2*CLK_DIV clk cycles; mosi changes while sclk=0, sclk rises at mid-bit; sclk idles 0.
REQ-018 NEXT: if contador_pixel == NUM_PIXELS-1 go DONE, else increment contador_pixel and go LOAD.
REQ-019 contador_pixel SHALL never exceed NUM_PIXELS-1 (no wrap to values outside the frame).
REQ-020 DONE: cs_n=1, busy=0, frame_done=1 for exactly one cycle, go IDLE.
REQ-021 start asserted in the DONE cycle SHALL be ignored; accepted from the following IDLE cycle.
REQ-022 No gaps in sclk within a pixel; inter-pixel gap SHALL be exactly 2 clk cycles (NEXT+LOAD).

Reset
REQ-023 rst=0 SHALL immediately force: state IDLE, adress=0, contador_pixel=0, spi_sclk=0, spi_mosi=0, spi_cs_n=1, spi_dc=0, busy=0, frame_done=0.
REQ-024 Reset mid-frame SHALL abort the transfer with no further sclk edges; next frame restarts from CMD.
REQ-025 Release of rst SHALL leave block in IDLE awaiting start.

Configuration
REQ-026 Macro AUTO_REFRESH_EN: defined -> DONE returns to CMD (re-latching estado) instead of IDLE, cs_n stays 0, busy stays 1, frame_done still pulses; start ignored after first frame.
REQ-027 Without AUTO_REFRESH_EN: behaviour per REQ-020, one frame per start.

Verification
REQ-028 NUM_PIXELS=4, CLK_DIV=1, memory model pixel=0xA500+index, start with estado=3 -> adress=3, bits on mosi: 0x2C (dc=0), then 0xA500,0xA501,0xA502,0xA503 (dc=1), frame_done one pulse.
REQ-029 Same setup, estado changed to 5 mid-frame -> adress stays 3 until DONE; second start sends adress=5.
REQ-030 estado=7 -> adress=0.
REQ-031 rst=0 during second pixel -> cs_n=1 and sclk=0 same cycle; after release start yields full 0x2C + 4 pixels.
REQ-032 CLK_DIV=3 -> sclk period 6 clk cycles, 8+64=72 sclk rising edges per frame, frame length counted exactly.
REQ-033 AUTO_REFRESH_EN defined -> two consecutive frames without start, frame_done pulse between, cs_n never high.
